xbar_rr_scheduler: RTL
======================

Name: xbar_rr_scheduler

Overview:
Per-output packet scheduler for the 4-input crossbar datapath. It holds one round-robin arbiter per egress port, default 6 egress ports. Each arbiter locks an egress port to one ingress queue from first beat to EOP beat. The block drives the crossbar select lines and the per-input beat-accept strobes, and applies egress backpressure.

Parameters:
NUM_IN, 4, number of ingress requesters (crossbar inputs)
NUM_OUT, 6, number of egress ports
DST_W, 3, width of a destination index; must satisfy 2**DST_W >= NUM_OUT
SEL_W, 2, width of an owner index; must satisfy 2**SEL_W >= NUM_IN

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset
req  in  NUM_IN  input i has a beat ready
req_dst  in  NUM_IN*DST_W  destination egress index of input i; field i at [i*DST_W +: DST_W]
req_eop  in  NUM_IN  current beat of input i is the last of its packet
out_rdy  in  NUM_OUT  egress o can accept a beat this cycle
gnt  out  NUM_IN  beat of input i transferred this cycle (combinational)
out_wr  out  NUM_OUT  egress o receives a beat this cycle (combinational)
out_sel  out  NUM_OUT*SEL_W  registered owner index of egress o (crossbar mux select)
out_busy  out  NUM_OUT  registered: egress o is locked to an owner
dst_err  out  1  sticky: a request named an egress >= NUM_OUT

Behaviour:
- Reset (rst=0, async): all egress FSMs IDLE; ptr[o]=0, out_sel=0, out_busy=0, dst_err=0. gnt and out_wr are 0 because no egress is locked.
- Requester rules:
  - Each input requests one egress at a time.
  - req_dst and req stay stable until the beat is granted.
  - req may drop between beats; the lock is kept.
- Per-egress FSM, IDLE -> LOCKED -> IDLE:
  - IDLE: candidate set C = {i : req[i] && req_dst[i]==o && input i not owner of any LOCKED egress}.
  - IDLE, C non-empty: pick the first i in C scanning ptr[o], ptr[o]+1, ... mod NUM_IN. Next cycle: LOCKED, out_sel[o]=i, out_busy[o]=1.
  - IDLE: no beat transfers. Arbitration costs a fixed 1-cycle bubble per packet.
  - LOCKED, owner k: out_wr[o] = gnt[k] = req[k] && out_rdy[o] && req_dst[k]==o.
  - LOCKED, transfer with req_eop[k]=1: next cycle IDLE, out_busy=0, ptr[o]=(k+1) mod NUM_IN. out_sel holds its last value.
  - Otherwise the FSM stays LOCKED. out_rdy=0 stalls the transfer with no state change.
- Multi-egress collisions:
  - An input already owning a LOCKED egress is excluded from all other egress candidate sets.
  - If two IDLE egresses select the same input in one cycle, it cannot happen: the input carries a single dst.
- Single-beat packet (eop on the first beat): locked for exactly 1 transfer cycle, then IDLE. Back-to-back single-beat packets from one input to one egress occupy 2 cycles per beat.
- Invalid destination:
  - req[i] with req_dst[i] >= NUM_OUT sets dst_err the next cycle.
  - dst_err holds until reset.
  - The request is never granted; no egress state changes.
- Pointer wrap: ptr increments modulo NUM_IN (3 -> 0).
- Reset mid-packet: lock is dropped immediately; no gnt until re-arbitration.
- Widths: ptr and owner are SEL_W bits. Comparisons use the full DST_W field, no truncation.

Optional Feature:
Macro XBAR_SCHED_STATS_EN.
- With the macro: adds output pkt_cnt, NUM_OUT*16 bits. Counter o increments on each out_wr[o] with the owner's req_eop=1, wraps 0xFFFF -> 0, and resets to 0.
- Adds output stall_cnt, NUM_OUT*16 bits. Counter o increments each cycle egress o is LOCKED with req[owner]=1 and out_rdy[o]=0; saturates at 0xFFFF.
- Without the macro: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- Single packet: reset, then input 0 sends 3 beats to egress 2 with out_rdy=1. Required: out_busy[2]=1 from cycle 1; gnt[0]/out_wr[2] high cycles 1-3; IDLE at cycle 4; ptr[2]=1.
- Contention: inputs 0-3 each send 2-beat packets to egress 5, all requesting at t0. Required grant order 0,1,2,3, each packet followed by a 1-cycle bubble; no beats interleave within a packet.
- Backpressure: input 1 locked on egress 0; out_rdy[0] held 0 for 4 cycles mid-packet. Required: gnt[1]=0 for those cycles, lock retained, out_sel[0]=1. With XBAR_SCHED_STATS_EN, stall_cnt[0]=4.
- Parallel egresses: input 0 -> egress 1 and input 3 -> egress 4 simultaneously. Required: both locked the same cycle; out_sel[1]=0 and out_sel[4]=3; concurrent gnt.
- Invalid destination: input 2 requests req_dst=7. Required: dst_err=1 the next cycle and held; gnt[2] never asserted; out_busy unchanged.
- Reset mid-packet: assert rst=0 during beat 2 of 4. Required: out_busy=0 and gnt=0 immediately; after release, re-arbitration starts with ptr=0.

Source files
------------

// File: rtl/xbar_rr_scheduler.sv
// Per-egress round-robin packet scheduler for the 4-input crossbar: each egress locks to one ingress from first beat to EOP.
// Define XBAR_SCHED_STATS_EN to add per-egress pkt_cnt / stall_cnt counters.
//
// state  | meaning
// IDLE   | egress free; arbitrates among requesters naming it, no beat moves
// LOCKED | egress owned by out_sel; beats pass until the owner's EOP transfers
module xbar_rr_scheduler #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 6,
    parameter int DST_W   = 3,
    parameter int SEL_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        req,
    input  logic [NUM_IN*DST_W-1:0]  req_dst,
    input  logic [NUM_IN-1:0]        req_eop,
    input  logic [NUM_OUT-1:0]       out_rdy,
    output logic [NUM_IN-1:0]        gnt,
    output logic [NUM_OUT-1:0]       out_wr,
    output logic [NUM_OUT*SEL_W-1:0] out_sel,
    output logic [NUM_OUT-1:0]       out_busy,
`ifdef XBAR_SCHED_STATS_EN
    output logic [NUM_OUT*16-1:0]    pkt_cnt,
    output logic [NUM_OUT*16-1:0]    stall_cnt,
`endif
    output logic                     dst_err
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    logic [NUM_IN-1:0] owned;
    logic [NUM_IN-1:0] bad_dst;

    // An input that already owns a locked egress may not compete for another one.
    always_comb begin
        owned = '0;
        for (int o = 0; o < NUM_OUT; o++)
            if (out_busy[o]) owned[out_sel[o*SEL_W +: SEL_W]] = 1'b1;
    end

    always_comb begin
        gnt = '0;
        for (int o = 0; o < NUM_OUT; o++)
            if (out_wr[o]) gnt[out_sel[o*SEL_W +: SEL_W]] = 1'b1;
    end

    always_comb begin
        bad_dst = '0;
        for (int i = 0; i < NUM_IN; i++)
            bad_dst[i] = req[i] && (int'(req_dst[i*DST_W +: DST_W]) >= NUM_OUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            dst_err <= 1'b0;
        else if (|bad_dst)
            dst_err <= 1'b1;
    end

    for (genvar o = 0; o < NUM_OUT; o++) begin : g_egr
        state_e            state_q, state_d;
        logic [SEL_W-1:0]  sel_q, sel_d, ptr_q, ptr_d, pick, owner_nxt;
        logic [NUM_IN-1:0] cand;
        logic [DST_W-1:0]  own_dst;
        logic              own_req, own_eop, hit, last_beat;

        always_comb begin
            cand = '0;
            for (int i = 0; i < NUM_IN; i++)
                cand[i] = req[i] && !owned[i] && (int'(req_dst[i*DST_W +: DST_W]) == o);
        end

        // First candidate at or after ptr, wrapping modulo NUM_IN.
        always_comb begin
            int               idx;
            logic [SEL_W-1:0] idx_s;
            pick  = '0;
            hit   = 1'b0;
            idx   = 0;
            idx_s = '0;
            for (int j = 0; j < NUM_IN; j++) begin
                idx = int'(ptr_q) + j;
                if (idx >= NUM_IN) idx = idx - NUM_IN;
                idx_s = SEL_W'(idx);
                if (!hit && cand[idx_s]) begin
                    pick = idx_s;
                    hit  = 1'b1;
                end
            end
        end

        always_comb begin
            own_req = 1'b0;
            own_eop = 1'b0;
            own_dst = '0;
            for (int i = 0; i < NUM_IN; i++)
                if (sel_q == SEL_W'(i)) begin
                    own_req = req[i];
                    own_eop = req_eop[i];
                    own_dst = req_dst[i*DST_W +: DST_W];
                end
        end

        assign out_busy[o]               = (state_q == LOCKED);
        assign out_sel[o*SEL_W +: SEL_W] = sel_q;
        assign out_wr[o]  = out_busy[o] && own_req && out_rdy[o] && (int'(own_dst) == o);
        assign last_beat  = out_wr[o] && own_eop;
        assign owner_nxt  = (sel_q == SEL_W'(NUM_IN - 1)) ? '0 : sel_q + 1'b1;

        always_comb begin
            state_d = state_q;
            sel_d   = sel_q;
            ptr_d   = ptr_q;
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        state_d = LOCKED;
                        sel_d   = pick;
                    end
                end
                LOCKED: begin
                    if (last_beat) begin
                        state_d = IDLE;
                        ptr_d   = owner_nxt;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                sel_q   <= '0;
                ptr_q   <= '0;
            end else begin
                state_q <= state_d;
                sel_q   <= sel_d;
                ptr_q   <= ptr_d;
            end
        end

`ifdef XBAR_SCHED_STATS_EN
        logic [15:0] pkt_q, stall_q;

        // Packet count wraps; stall count saturates.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pkt_q   <= '0;
                stall_q <= '0;
            end else begin
                if (last_beat)
                    pkt_q <= pkt_q + 16'd1;
                if (out_busy[o] && own_req && !out_rdy[o] && (stall_q != 16'hFFFF))
                    stall_q <= stall_q + 16'd1;
            end
        end

        assign pkt_cnt[o*16 +: 16]   = pkt_q;
        assign stall_cnt[o*16 +: 16] = stall_q;
`endif
    end

endmodule
